// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM states and defaults shared by the load/store unit.
package lsu_pkg;
    localparam int MEM_WORDS_DEFAULT = 2048;
    typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2, SZ_ILL = 2'd3} size_e;
    typedef enum logic [1:0] {IDLE, LOAD, MERGE, ERR} state_e;
    function automatic logic misaligned(size_e size, logic [1:0] offset);
        return (size == SZ_HALF && offset[0]) || (size == SZ_WORD && offset != 2'b00);
    endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: pipeline request/response channel plus the data_memory port of the load/store unit.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic        mem_operation;
    logic [31:0] mem_write_data;
    logic [31:0] mem_data;
    modport master(
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_data,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_operation, mem_write_data
    );
    modport slave(
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_data,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_operation, mem_write_data
    );
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extract with sign/zero extension, and sub-word lane merge.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  size_e       size,
    input  logic        zext,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);
    logic [4:0]  sh;
    logic [15:0] lane;
    logic [31:0] mask;
    assign sh     = {offset, 3'b000};
    assign lane   = 16'(word >> sh);
    assign mask   = (size == SZ_BYTE ? 32'h0000_00ff : size == SZ_HALF ? 32'h0000_ffff : 32'hffff_ffff) << sh;
    assign rdata  = size == SZ_BYTE ? {{24{~zext & lane[7]}}, lane[7:0]} :
                    size == SZ_HALF ? {{16{~zext & lane[15]}}, lane[15:0]} : word;
    assign merged = (word & ~mask) | ((wdata << sh) & mask);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores to data_memory with read-modify-write
// for sub-word stores and error detection that never touches memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input logic  clk,
    input logic  rst_n,
    lsu_if.slave bus
);
    state_e      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    size_e       size_q;
    logic        zext_q;
    size_e       req_size;
    logic        accept;
    logic        bad;
    logic        word_store;
    logic [31:0] rdata;
    logic [31:0] merged;
    assign req_size   = size_e'(bus.req_size);
    assign bus.req_ready = rst_n && state == IDLE;
    assign accept     = bus.req_valid && bus.req_ready;
    assign bad        = req_size == SZ_ILL || misaligned(req_size, bus.req_addr[1:0]) ||
                        {6'b0, bus.req_addr[27:2]} >= 32'(MEM_WORDS);
    assign word_store = accept && !bad && bus.req_write && req_size == SZ_WORD;
    // Memory port is combinational so the RAM sees the write or read in the same cycle.
    assign bus.mem_address    = state == IDLE ? bus.req_addr : addr_q;
    assign bus.mem_operation  = rst_n && (word_store || state == MERGE);
    assign bus.mem_write_data = state == MERGE ? merged : bus.req_wdata;
    lsu_lane_align u_align (
        .word  (bus.mem_data),
        .offset(addr_q[1:0]),
        .size  (size_q),
        .zext  (zext_q),
        .wdata (wdata_q),
        .rdata (rdata),
        .merged(merged)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            size_q         <= SZ_BYTE;
            zext_q         <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
        end else begin
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            case (state)
                IDLE: if (accept) begin
                    addr_q  <= bus.req_addr;
                    wdata_q <= bus.req_wdata;
                    size_q  <= req_size;
                    zext_q  <= bus.req_unsigned;
                    if (bad) begin
                        state          <= ERR;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                    end else if (word_store) begin
                        bus.resp_valid <= 1'b1;
                    end else begin
                        state <= bus.req_write ? MERGE : LOAD;
                    end
                end
                LOAD: begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_rdata <= rdata;
                    state          <= IDLE;
                end
                MERGE: begin
                    bus.resp_valid <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table vectors, corner sequences and random traffic against a word-array model.
module tb_load_store_unit;
    localparam int W = 256;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] ram     [W] = '{default: 32'h0};
    logic [31:0] ref_mem [W] = '{default: 32'h0};

    lsu_if bus ();
    load_store_unit #(.MEM_WORDS(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Behavioural stand-in for data_memory: registered read, write on the same edge.
    always @(posedge clk) begin
        if (bus.mem_operation && bus.mem_address[27:2] < W) ram[bus.mem_address[27:2]] <= bus.mem_write_data;
        bus.mem_data <= (bus.mem_address[27:2] < W) ? ram[bus.mem_address[27:2]] : 32'h0;
    end

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          nw;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat, output int nw);
        longint idx, k, bits, m, lane, word;
        idx  = longint'(a[27:2]);
        k    = longint'(a[1:0]);
        bits = sz == 2'd0 ? 8 : sz == 2'd1 ? 16 : 32;
        er   = sz == 2'd3 || (longint'(a) % (bits / 8)) != 0 || idx >= W;
        rd   = 32'h0;
        lat  = 1;
        nw   = 0;
        if (er) return;
        m    = (64'd1 << bits) - 1;
        word = longint'(ref_mem[idx]);
        lane = (word >> (8 * k)) & m;
        if (w) begin
            ref_mem[idx] = 32'((word & ~(m << (8 * k))) | ((longint'(wd) & m) << (8 * k)));
            lat = bits == 32 ? 1 : 2;
            nw  = 1;
        end else begin
            rd  = 32'((!u && lane > m / 2) ? lane - (m + 1) : lane);
            lat = 2;
        end
    endtask

    task automatic req(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat, output int nw);
        int t;
        @(posedge clk); #1;
        t = 0;
        while (!bus.req_ready && t < 10) begin
            @(posedge clk); #1;
            t++;
        end
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_size = sz;
        bus.req_unsigned = u;
        bus.req_addr = a;
        bus.req_wdata = wd;
        nw = 0;
        rd = 32'hx;
        er = 1'bx;
        lat = 99;
        @(negedge clk);
        nw += int'(bus.mem_operation);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (bus.resp_valid) begin
                rd = bus.resp_rdata;
                er = bus.resp_err;
                lat = i;
                break;
            end
            @(negedge clk);
            nw += int'(bus.mem_operation);
            @(posedge clk); #1;
        end
    endtask

    vec_t        vecs[$];
    logic [31:0] rd, mrd;
    logic        er, mer;
    int          lat, nw, mlat, mnw, acc, pulses, mism;
    logic [31:0] a;
    logic [1:0]  sz;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("rst_resp_err", 32'(bus.resp_err), 0);
        chk("rst_resp_rdata", bus.resp_rdata, 0);
        chk("rst_mem_op", 32'(bus.mem_operation), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", 32'(bus.req_ready), 1);

        //         w     sz     u     addr           wdata          rdata          er    lat nw
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h10,       32'hAABBCCDD, 32'h0,        1'b0, 1, 1});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h12,       32'hFFFFFF11, 32'h0,        1'b0, 2, 1});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        32'hAA11CCDD, 1'b0, 2, 0});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h20,       32'h0000F080, 32'h0,        1'b0, 1, 1});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h20,       32'h0,        32'hFFFFFF80, 1'b0, 2, 0});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h20,       32'h0,        32'h00000080, 1'b0, 2, 0});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h20,       32'h0,        32'hFFFFF080, 1'b0, 2, 0});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h21,       32'h0,        32'h0,        1'b1, 1, 0});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'(W * 4),   32'hDEADBEEF, 32'h0,        1'b1, 1, 0});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h22,       32'h0,        32'h0,        1'b0, 2, 0});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h13,       32'h0,        32'hFFFFFFAA, 1'b0, 2, 0});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h12,       32'h1234BEEF, 32'h0,        1'b0, 2, 1});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h12,       32'h0,        32'h0000BEEF, 1'b0, 2, 0});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h10,       32'h0,        32'h0,        1'b1, 1, 0});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'(W * 4 - 4), 32'h01020304, 32'h0,      1'b0, 1, 1});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'(W * 4 - 4), 32'h0,      32'h01020304, 1'b0, 2, 0});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h10000010, 32'h0,        32'hBEEFCCDD, 1'b0, 2, 0});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h30,       32'h12345678, 32'h0,        1'b0, 1, 1});
        foreach (vecs[i]) begin
            req(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd, rd, er, lat, nw);
            model(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd, mrd, mer, mlat, mnw);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rd);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].er));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_writes", i), 32'(nw), 32'(vecs[i].nw));
        end

        // Back-to-back word stores with req_valid held high.
        @(posedge clk); #1;
        acc = 0;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 1'b1;
            bus.req_write = 1'b1;
            bus.req_size = 2'd2;
            bus.req_addr = 32'h40 + 32'(i * 4);
            bus.req_wdata = 32'hC0DE0000 + 32'(i);
            model(1'b1, 2'd2, 1'b0, bus.req_addr, bus.req_wdata, mrd, mer, mlat, mnw);
            @(negedge clk);
            acc += int'(bus.req_ready && bus.mem_operation);
            @(posedge clk); #1;
            pulses += int'(bus.resp_valid);
        end
        bus.req_valid = 1'b0;
        chk("burst_accepts", 32'(acc), 4);
        chk("burst_pulses", 32'(pulses), 4);
        @(posedge clk); #1;
        chk("burst_idle_after", 32'(bus.resp_valid), 0);

        // Reset asserted while a half store is in MERGE.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size = 2'd1;
        bus.req_addr = 32'h30;
        bus.req_wdata = 32'h0000AAAA;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_wdata = 32'h0;
        bus.req_addr = 32'h0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_mem_op", 32'(bus.mem_operation), 0);
        @(posedge clk); #1;
        chk("abort_resp_valid", 32'(bus.resp_valid), 0);
        chk("abort_resp_err", 32'(bus.resp_err), 0);
        chk("abort_resp_rdata", bus.resp_rdata, 0);
        chk("abort_mem_op_after", 32'(bus.mem_operation), 0);
        chk("abort_ready", 32'(bus.req_ready), 0);
        rst_n = 1'b1;
        req(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, rd, er, lat, nw);
        chk("abort_readback", rd, 32'h12345678);

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            sz = 2'($urandom_range(0, 3));
            a = ($urandom & 32'hF000_0000) | (32'($urandom_range(0, W + 3)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            req(1'($urandom), sz, 1'($urandom), a, $urandom, rd, er, lat, nw);
            model(bus.req_write, sz, bus.req_unsigned, a, bus.req_wdata, mrd, mer, mlat, mnw);
            chk($sformatf("rnd%0d_rdata", n), rd, mrd);
            chk($sformatf("rnd%0d_err", n), 32'(er), 32'(mer));
            chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(mlat));
            chk($sformatf("rnd%0d_writes", n), 32'(nw), 32'(mnw));
        end

        @(posedge clk); #1;
        mism = 0;
        for (int i = 0; i < W; i++) mism += int'(ram[i] !== ref_mem[i]);
        chk("ram_contents_mismatches", 32'(mism), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
